// File: rtl/contador_pkg.sv
// rtl/contador_pkg.sv - shared types and sizing helpers for the up/down counter
package contador_pkg;

    typedef enum logic [1:0] {
        WRAP_UP   = 2'b00,
        WRAP_DOWN = 2'b01,
        BOUNCE    = 2'b10,
        SAT_UP    = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        S_UP       = 2'b00,
        S_DWELL_HI = 2'b01,
        S_DOWN     = 2'b10,
        S_DWELL_LO = 2'b11
    } bstate_e;

    localparam int DWELL_DEFAULT = 1;

    // Dwell counter width; kept at least one bit so DWELL=0 still elaborates.
    function automatic int dwell_width(input int dwell);
        return (dwell < 1) ? 1 : $clog2(dwell + 1);
    endfunction

endpackage

// File: rtl/contador_step_calc.sv
// rtl/contador_step_calc.sv - combinational next-value, bound-hit and wrap detection
module contador_step_calc
    import contador_pkg::*;
#(
    parameter int W    = 4,
    parameter int STEP = 1
) (
    input  logic    [W-1:0] saida,
    input  logic    [W-1:0] limit_lo,
    input  logic    [W-1:0] limit_hi,
    input  mode_e           mode,
    input  bstate_e         state,
    output logic    [W-1:0] next_value,
    output logic            hit_hi,
    output logic            hit_lo,
    output logic            wrap
);

    localparam logic [W:0] STEP_X = (W+1)'(STEP);

    logic [W:0] cur;
    logic [W:0] lo_x;
    logic [W:0] hi_x;
    logic [W:0] up;
    logic [W:0] down;
    logic       down_neg;

    // One extra bit so the up candidate never overflows; down sign comes from a compare.
    assign cur      = {1'b0, saida};
    assign lo_x     = {1'b0, limit_lo};
    assign hi_x     = {1'b0, limit_hi};
    assign up       = cur + STEP_X;
    assign down     = cur - STEP_X;
    assign down_neg = STEP_X > cur;

    always_comb begin
        next_value = saida;
        wrap       = 1'b0;
        if (saida < limit_lo) begin
            next_value = limit_lo;
        end else if (saida > limit_hi) begin
            next_value = limit_hi;
        end else begin
            case (mode)
                WRAP_UP: begin
                    if (up > hi_x) begin
                        next_value = limit_lo;
                        wrap       = 1'b1;
                    end else begin
                        next_value = up[W-1:0];
                    end
                end
                WRAP_DOWN: begin
                    if (down_neg || (down < lo_x)) begin
                        next_value = limit_hi;
                        wrap       = 1'b1;
                    end else begin
                        next_value = down[W-1:0];
                    end
                end
                SAT_UP: begin
                    next_value = (up >= hi_x) ? limit_hi : up[W-1:0];
                end
                default: begin
                    case (state)
                        S_UP:    next_value = (up >= hi_x) ? limit_hi : up[W-1:0];
                        S_DOWN:  next_value = (down_neg || (down <= lo_x)) ? limit_lo : down[W-1:0];
                        default: next_value = saida;
                    endcase
                end
            endcase
        end
    end

    assign hit_hi = (next_value == limit_hi);
    assign hit_lo = (next_value == limit_lo);

endmodule

// File: rtl/contador_updown_param.sv
// rtl/contador_updown_param.sv - parametrised up/down counter with wrap, bounce and saturate modes
module contador_updown_param
    import contador_pkg::*;
#(
    parameter int W     = 4,
    parameter int STEP  = 1,
    parameter int DWELL = DWELL_DEFAULT
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         enable,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic [1:0]   mode,
    input  logic [W-1:0] limit_lo,
    input  logic [W-1:0] limit_hi,
    output logic [W-1:0] saida,
    output logic         dir,
    output logic         at_limit,
    output logic         wrapped,
    output logic         cfg_err
);

    localparam int                 DWELL_W    = dwell_width(DWELL);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'((DWELL > 0) ? DWELL - 1 : 0);
    localparam bstate_e            AFTER_HI   = (DWELL == 0) ? S_DOWN : S_DWELL_HI;
    localparam bstate_e            AFTER_LO   = (DWELL == 0) ? S_UP : S_DWELL_LO;

    bstate_e              state;
    logic   [DWELL_W-1:0] dwell_cnt;
    mode_e                mode_q;
    logic   [W-1:0]       next_value;
    logic   [W-1:0]       load_clamped;
    logic                 hit_hi;
    logic                 hit_lo;
    logic                 wrap;
    logic                 bad_cfg;
    logic                 changed;
    bstate_e              resume_state;

    assign mode_q       = mode_e'(mode);
    assign bad_cfg      = limit_lo > limit_hi;
    assign changed      = next_value != saida;
    assign resume_state = dir ? S_DOWN : S_UP;
    assign load_clamped = (load_value < limit_lo) ? limit_lo :
                          (load_value > limit_hi) ? limit_hi : load_value;

    contador_step_calc #(
        .W    (W),
        .STEP (STEP)
    ) u_step (
        .saida      (saida),
        .limit_lo   (limit_lo),
        .limit_hi   (limit_hi),
        .mode       (mode_q),
        .state      (state),
        .next_value (next_value),
        .hit_hi     (hit_hi),
        .hit_lo     (hit_lo),
        .wrap       (wrap)
    );

    // dir records the direction of the last real step, so it flips on the first move away from a bound.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            saida     <= '0;
            dir       <= 1'b0;
            at_limit  <= 1'b0;
            wrapped   <= 1'b0;
            cfg_err   <= 1'b0;
            state     <= S_UP;
            dwell_cnt <= '0;
        end else begin
            at_limit <= 1'b0;
            wrapped  <= 1'b0;
            cfg_err  <= bad_cfg;
            if (!bad_cfg) begin
                if (clear) begin
                    saida     <= limit_lo;
                    dir       <= 1'b0;
                    state     <= S_UP;
                    dwell_cnt <= '0;
                    at_limit  <= saida != limit_lo;
                end else if (load) begin
                    saida     <= load_clamped;
                    state     <= resume_state;
                    dwell_cnt <= '0;
                    at_limit  <= (load_clamped == limit_lo) || (load_clamped == limit_hi);
                end else if (enable) begin
                    saida    <= next_value;
                    at_limit <= changed && (hit_hi || hit_lo);
                    wrapped  <= changed && wrap;
                    case (mode_q)
                        BOUNCE: begin
                            case (state)
                                S_UP: begin
                                    dir <= 1'b0;
                                    if (hit_hi) begin
                                        state     <= AFTER_HI;
                                        dwell_cnt <= '0;
                                    end else if (hit_lo) begin
                                        state     <= AFTER_LO;
                                        dwell_cnt <= '0;
                                    end
                                end
                                S_DOWN: begin
                                    dir <= 1'b1;
                                    if (hit_lo) begin
                                        state     <= AFTER_LO;
                                        dwell_cnt <= '0;
                                    end else if (hit_hi) begin
                                        state     <= AFTER_HI;
                                        dwell_cnt <= '0;
                                    end
                                end
                                S_DWELL_HI: begin
                                    if (dwell_cnt == DWELL_LAST) begin
                                        state     <= S_DOWN;
                                        dwell_cnt <= '0;
                                    end else begin
                                        dwell_cnt <= dwell_cnt + 1'b1;
                                    end
                                end
                                default: begin
                                    if (dwell_cnt == DWELL_LAST) begin
                                        state     <= S_UP;
                                        dwell_cnt <= '0;
                                    end else begin
                                        dwell_cnt <= dwell_cnt + 1'b1;
                                    end
                                end
                            endcase
                        end
                        WRAP_DOWN: begin
                            dir       <= 1'b1;
                            state     <= S_DOWN;
                            dwell_cnt <= '0;
                        end
                        default: begin
                            dir       <= 1'b0;
                            state     <= S_UP;
                            dwell_cnt <= '0;
                        end
                    endcase
                end
            end
        end
    end

endmodule
